// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
// Imported by the arbiter top and its pick helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  localparam int DEF_DEPTH = 64;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
// On a tie the port that was not served last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_winner
);

  assign o_valid  = i_req0 | i_req1;
  assign o_winner = (i_req0 & i_req1) ? ~i_last
                  : (i_req1 ? PORT_DATA : PORT_IF);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port shared-memory arbiter, one transaction per 3 cycles.
// IDLE accepts a request, SERVE strobes memory, RESP returns done/rdata/err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p0_gnt,
  output logic          p0_done,
  output logic [31:0]   p0_rdata,
  output logic          p0_err,
  output logic          p1_gnt,
  output logic          p1_done,
  output logic [31:0]   p1_rdata,
  output logic          p1_err,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [31:0]   mem_rdata
);

  localparam logic [AW-1:0] LIM = AW'(DEPTH);

  state_t        r_state;
  logic          r_last;
  logic          r_port;
  logic          r_we;
  logic          r_ok;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_wr;
  logic          r_rd;
  logic          r_done0;
  logic          r_done1;
  logic          r_err0;
  logic          r_err1;
  logic [31:0]   r_rdata0;
  logic [31:0]   r_rdata1;

  logic          w_valid;
  logic          w_win;
  logic          w_we;
  logic          w_ok;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_wdata;
  logic [31:0]   w_cap;

  rr_pick2 u_pick (
    .i_req0   (p0_req),
    .i_req1   (p1_req),
    .i_last   (r_last),
    .o_valid  (w_valid),
    .o_winner (w_win)
  );

  assign w_we    = w_win ? p1_we    : p0_we;
  assign w_addr  = w_win ? p1_addr  : p0_addr;
  assign w_wdata = w_win ? p1_wdata : p0_wdata;
  assign w_ok    = w_addr < LIM;
  // r_rd already means "legal read", so it gates the capture
  assign w_cap   = r_rd ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_last   <= PORT_DATA;
      r_port   <= PORT_IF;
      r_we     <= 1'b0;
      r_ok     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_port  <= w_win;
            r_last  <= w_win;
            r_we    <= w_we;
            r_ok    <= w_ok;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_wr    <= w_we & w_ok;
            r_rd    <= ~w_we & w_ok;
            r_state <= SERVE;
          end
        end
        SERVE: begin
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          r_wr     <= 1'b0;
          r_rd     <= 1'b0;
          r_done0  <= ~r_port;
          r_done1  <= r_port;
          r_err0   <= ~r_port & ~r_ok;
          r_err1   <= r_port & ~r_ok;
          r_rdata0 <= r_port ? '0 : w_cap;
          r_rdata1 <= r_port ? w_cap : '0;
          r_state  <= RESP;
        end
        RESP: begin
          r_done0  <= 1'b0;
          r_done1  <= 1'b0;
          r_err0   <= 1'b0;
          r_err1   <= 1'b0;
          r_rdata0 <= '0;
          r_rdata1 <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign p0_gnt    = r_gnt0;
  assign p1_gnt    = r_gnt1;
  assign p0_done   = r_done0;
  assign p1_done   = r_done1;
  assign p0_err    = r_err0;
  assign p1_err    = r_err1;
  assign p0_rdata  = r_rdata0;
  assign p1_rdata  = r_rdata1;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_write = r_wr;
  assign mem_read  = r_rd;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks against a transaction-level
// model (accept -> grant cycle -> done cycle -> free), plus a memory model.
module tb_mem_arbiter;

  localparam int DEPTH = 64;
  localparam int AW    = 32;
  localparam int IW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          p0_req = 1'b0, p1_req = 1'b0;
  logic          p0_we = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [31:0]   p0_wdata = '0, p1_wdata = '0;
  logic          p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err;
  logic [31:0]   p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_write, mem_read;

  mem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p0_err(p0_err),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_arr [DEPTH];
  assign mem_rdata = (mem_addr < DEPTH) ? mem_arr[mem_addr[IW-1:0]]
                                        : 32'hBAD0_BAD0;
  always @(posedge clk)
    if (mem_write && mem_addr < DEPTH)
      mem_arr[mem_addr[IW-1:0]] <= mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // transaction-level reference: phase 0 free, 1 granted, 2 completing
  int          m_phase;
  bit          m_last, m_port, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [31:0] ref_mem [DEPTH];

  task automatic model_reset();
    m_phase = 0;
    m_last  = 1'b1;
    m_port  = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_rdata = '0;
  endtask

  task automatic model_edge();
    bit w;
    if (!rst) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: if (p0_req || p1_req) begin
        w       = (p0_req && p1_req) ? !m_last : p1_req;
        m_last  = w;
        m_port  = w;
        m_we    = w ? p1_we : p0_we;
        m_addr  = w ? p1_addr : p0_addr;
        m_wdata = w ? p1_wdata : p0_wdata;
        m_phase = 1;
      end
      1: begin
        m_rdata = 0;
        if (m_addr < DEPTH) begin
          if (m_we) ref_mem[m_addr[IW-1:0]] = m_wdata;
          else      m_rdata = ref_mem[m_addr[IW-1:0]];
        end
        m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_all();
    bit sv, rs, ok;
    sv = (m_phase == 1);
    rs = (m_phase == 2);
    ok = (m_addr < DEPTH);
    chk("p0_gnt", 32'(p0_gnt), 32'(sv && !m_port));
    chk("p1_gnt", 32'(p1_gnt), 32'(sv && m_port));
    chk("mem_write", 32'(mem_write), 32'(sv && m_we && ok));
    chk("mem_read", 32'(mem_read), 32'(sv && !m_we && ok));
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("p0_done", 32'(p0_done), 32'(rs && !m_port));
    chk("p1_done", 32'(p1_done), 32'(rs && m_port));
    chk("p0_rdata", p0_rdata, (rs && !m_port) ? m_rdata : 32'd0);
    chk("p1_rdata", p1_rdata, (rs && m_port) ? m_rdata : 32'd0);
    chk("p0_err", 32'(p0_err), 32'(rs && !m_port && !ok));
    chk("p1_err", 32'(p1_err), 32'(rs && m_port && !ok));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_all();
  endtask

  task automatic set_p(int p, bit rq, bit we, logic [31:0] a, logic [31:0] d);
    if (p == 0) begin
      p0_req = rq; p0_we = we; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = rq; p1_we = we; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic do_reset();
    set_p(0, 0, 0, 0, 0);
    set_p(1, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
    if (r == 1) return 32'(DEPTH + $urandom_range(0, 20));
    if (r == 2) return 32'(DEPTH - 1);
    return 32'($urandom_range(0, 15));
  endfunction

  int order[$];
  int dcyc[$];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    model_reset();
    #1;
    check_all();
    do_reset();

    // single read of a preloaded word
    mem_arr[5] = 32'd7;
    ref_mem[5] = 32'd7;
    set_p(0, 1, 0, 5, 0);
    tick();
    chk("rd_gnt", 32'(p0_gnt), 32'd1);
    tick();
    chk("rd_val", p0_rdata, 32'd7);
    set_p(0, 0, 0, 0, 0);
    tick();

    // write then read the same word
    set_p(1, 1, 1, 10, 32'hDEAD_BEEF);
    tick();
    tick();
    set_p(1, 1, 0, 10, 0);
    tick();
    tick();
    tick();
    chk("wr_rd_val", p1_rdata, 32'hDEAD_BEEF);
    set_p(1, 0, 0, 0, 0);
    tick();

    // out-of-range write
    set_p(1, 1, 1, 64, 32'h1234_5678);
    tick();
    chk("oor_nowr", 32'(mem_write), 32'd0);
    tick();
    chk("oor_err", 32'(p1_err), 32'd1);
    set_p(1, 0, 0, 0, 0);
    tick();

    // contention from reset
    do_reset();
    set_p(0, 1, 0, 1, 0);
    set_p(1, 1, 0, 2, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (p0_gnt) order.push_back(0);
      if (p1_gnt) order.push_back(1);
      if (p0_done || p1_done) dcyc.push_back(cyc);
    end
    chk("cont_ngnt", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk("cont_order", 32'(order[i]), 32'(i % 2));
    for (int i = 1; i < dcyc.size(); i++)
      chk("cont_gap", 32'(dcyc[i] - dcyc[i-1]), 32'd3);

    // reset asserted mid-write
    do_reset();
    set_p(1, 1, 1, 3, 32'hCAFE_F00D);
    tick();
    chk("rst_pre_wr", 32'(mem_write), 32'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_async_wr", 32'(mem_write), 32'd0);
    check_all();
    set_p(0, 1, 0, 4, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_tie_p0", 32'(p0_gnt), 32'd1);
    tick();
    set_p(0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    chk("rst_p1_next", 32'(p1_done), 32'd1);
    chk("rst_nowrite", p1_rdata, 32'd0);

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        bit rq, dn;
        rq = (p == 0) ? p0_req : p1_req;
        dn = (m_phase == 2) && (int'(m_port) == p);
        if ((rq && dn) || (!rq && $urandom_range(0, 9) < 4)) begin
          if (rq && $urandom_range(0, 1) == 0)
            set_p(p, 0, 0, 0, 0);
          else
            set_p(p, 1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
